instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch-stage controller between `program_counter` and the ID stage of the pipelined CPU. It drives the instruction-memory request from the current PC and computes `npc` for `program_counter`. Because `program_counter` has no enable, this block holds the PC by returning `npc = pc`. It also owns the IF/ID pipeline register, a one-entry skid buffer for ID stalls, and squashing of wrong-path fetches on redirects.

## Interface
Parameters:
- none; every reset value is zero, matching the `program_counter` reset value.

Ports:
- `clk`  in  1  system clock; every register updates on the rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `pc`  in  32  current PC from `program_counter`.
- `npc`  out  32  next PC to `program_counter`; combinational.
- `imem_addr`  out  32  equals `pc`; combinational.
- `imem_req`  out  1  fetch request; combinational from state.
- `imem_rdata`  in  32  instruction word; valid when `imem_ready` = 1.
- `imem_ready`  in  1  data-valid strobe; may assert in the same cycle as `imem_req` (zero wait).
- `stall_id`  in  1  ID stall (load-use); holds IF/ID and PC.
- `pcsource`  in  2  redirect select from ID: 00 = pc+4, 01 = `bpc`, 10 = `rpc`, 11 = `jpc`.
- `bpc`, `rpc`, `jpc`  in  32 each  branch, register (jr) and jump targets.
- `dpc4`  out  32  IF/ID register: pc+4 of the held instruction.
- `inst`  out  32  IF/ID register: instruction word; 0 (nop) when invalid.
- `inst_valid`  out  1  IF/ID register: valid bit.

## Operation
- Definitions:
  - `pc4` = `pc` + 4, modulo 2^32 (wraps 0xFFFFFFFC → 0).
  - `redirect` = (`pcsource` != 00) & ~`stall_id`. Redirects are ignored while ID is stalled.
  - `target` = the `pcsource` mux output.
- No delay slot: a redirect squashes the fetch in flight.
- "Bubble" means IF/ID ← {0, 0, 0}. "Hold" means IF/ID keeps its value.
- States: FETCH, HOLD, DRAIN. Internal registers: `buf` (32), `redir_q` (32).
- FETCH: `imem_req` = 1.
  - `stall_id` & `imem_ready`: `buf` ← `imem_rdata`; IF/ID hold; `npc` = `pc`; go to HOLD.
  - `stall_id` & ~`imem_ready`: IF/ID hold; `npc` = `pc`.
  - `redirect` & `imem_ready`: data discarded; IF/ID bubble; `npc` = `target`.
  - `redirect` & ~`imem_ready`: `redir_q` ← `target`; IF/ID bubble; `npc` = `pc`; go to DRAIN.
  - `imem_ready`: IF/ID ← {`pc4`, `imem_rdata`, 1}; `npc` = `pc4`.
  - Otherwise (waiting): IF/ID bubble; `npc` = `pc`.
- HOLD: `imem_req` = 0; `npc` = `pc`, except where noted below.
  - `stall_id`: IF/ID hold.
  - `redirect`: `buf` discarded; IF/ID bubble; `npc` = `target`; go to FETCH.
  - Otherwise: IF/ID ← {`pc4`, `buf`, 1}; `npc` = `pc4`; go to FETCH.
- DRAIN: `imem_req` = 1 at the old `pc` (the request is never withdrawn before `imem_ready`).
  - IF/ID bubble, or hold if `stall_id`.
  - `redirect`: `redir_q` ← `target` (the latest redirect wins).
  - `imem_ready`: data discarded; `npc` = `redir_q`, or `target` if a redirect is present in the same cycle; go to FETCH.
  - Otherwise: `npc` = `pc`.
- At most one request is outstanding. Fetched data never reaches IF/ID on a squashed path.

## Timing
- Reset (`clrn` = 0, asynchronous):
  - State = FETCH; `dpc4` = 0, `inst` = 0, `inst_valid` = 0; `buf` = 0, `redir_q` = 0.
  - With `pc` = 0, `imem_req` = 1 and `imem_addr` = 0 immediately.
- Zero-wait memory: one instruction per cycle. The instruction fetched at `pc` appears in IF/ID after 1 edge.
- Redirect penalty:
  - With the in-flight fetch ready: 1 bubble.
  - In DRAIN: 1 + the remaining wait cycles.
- `stall_id` release from HOLD: the buffered instruction enters IF/ID on the next edge with no refetch.
- Reset asserted mid-DRAIN or mid-HOLD: the pending target and buffer are lost; fetch restarts at `pc` (0 after reset).

## Test plan
- Reset, then `imem_ready` tied to 1 -> `pc` runs 0, 4, 8. After edge 1, IF/ID = {4, word@0, 1}; after edge 2, IF/ID = {8, word@4, 1}.
- `imem_ready` low for 2 cycles at `pc` = 8 -> `npc` = 8 and `inst_valid` = 0 for both cycles. On ready, IF/ID = {0xC, word@8, 1} and `npc` = 0xC.
- `pcsource` = 01, `bpc` = 0x100, ready = 1 at `pc` = 0x20 -> `npc` = 0x100; the next IF/ID is {0, 0, 0}; word@0x20 is never valid.
- `pcsource` = 11, `jpc` = 0x200 at `pc` = 0x10 with ready low for 3 cycles -> `pc` stays 0x10, `imem_req` stays 1. On ready, `npc` = 0x200 and `inst_valid` stays 0 throughout.
- `stall_id` = 1 with ready = 1 at `pc` = 0x40 -> HOLD, `imem_req` = 0, IF/ID unchanged for 2 cycles. On release, IF/ID = {0x44, word@0x40, 1} and `npc` = 0x44.
- `clrn` pulsed low in DRAIN -> outputs zero immediately, state FETCH, `imem_req` = 1. The post-reset fetch is at 0 and the old `redir_q` is never used.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch-stage controller: drives the instruction-memory request from the PC, picks npc,
// and owns the IF/ID register with a one-entry skid buffer and redirect squashing.
module instruction_fetch (
   input  logic        clk,
   input  logic        clrn,
   input  logic [31:0] pc,
   output logic [31:0] npc,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall_id,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic [31:0] dpc4,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;
   typedef enum logic [1:0] {IFID_HOLD = 2'd0, IFID_BUBBLE = 2'd1, IFID_LOAD = 2'd2} ifid_op_t;

   state_t      state, state_nx;
   ifid_op_t    ifid_op;
   logic [31:0] buf_q, redir_q;
   logic [31:0] ifid_word;
   logic        buf_load, redir_load;
   logic [31:0] pc4, target;
   logic        redirect;

   assign pc4       = pc + 32'd4;
   assign redirect  = (pcsource != 2'b00) && !stall_id;
   assign imem_addr = pc;
   assign fsm_state = state;

   always_comb begin
      unique case (pcsource)
         2'b01:   target = bpc;
         2'b10:   target = rpc;
         2'b11:   target = jpc;
         default: target = pc4;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= FETCH;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         FETCH: begin
            if (stall_id && imem_ready)       state_nx = HOLD;
            else if (redirect && !imem_ready) state_nx = DRAIN;
         end
         HOLD:    if (!stall_id)  state_nx = FETCH;
         DRAIN:   if (imem_ready) state_nx = FETCH;
         default: state_nx = FETCH;
      endcase
   end

   always_comb begin
      npc        = pc;
      imem_req   = 1'b1;
      ifid_op    = IFID_BUBBLE;
      ifid_word  = imem_rdata;
      buf_load   = 1'b0;
      redir_load = 1'b0;
      unique case (state)
         FETCH: begin
            if (stall_id) begin
               ifid_op  = IFID_HOLD;
               buf_load = imem_ready;
            end else if (redirect) begin
               // A ready fetch on the wrong path is dropped; otherwise remember the target.
               if (imem_ready) npc = target;
               else            redir_load = 1'b1;
            end else if (imem_ready) begin
               ifid_op = IFID_LOAD;
               npc     = pc4;
            end
         end
         HOLD: begin
            imem_req = 1'b0;
            if (stall_id) begin
               ifid_op = IFID_HOLD;
            end else if (redirect) begin
               npc = target;
            end else begin
               ifid_op   = IFID_LOAD;
               ifid_word = buf_q;
               npc       = pc4;
            end
         end
         DRAIN: begin
            // Request stays up at the old pc until the squashed word comes back.
            if (stall_id) ifid_op = IFID_HOLD;
            redir_load = redirect;
            if (imem_ready) npc = redirect ? target : redir_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         buf_q   <= 32'd0;
         redir_q <= 32'd0;
      end else begin
         if (buf_load)   buf_q   <= imem_rdata;
         if (redir_load) redir_q <= target;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         dpc4       <= 32'd0;
         inst       <= 32'd0;
         inst_valid <= 1'b0;
      end else begin
         unique case (ifid_op)
            IFID_LOAD: begin
               dpc4       <= pc4;
               inst       <= ifid_word;
               inst_valid <= 1'b1;
            end
            IFID_BUBBLE: begin
               dpc4       <= 32'd0;
               inst       <= 32'd0;
               inst_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a PC register and a combinational instruction
// memory surround the DUT; inputs change and outputs are checked on the falling edge.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] pc;
   logic [31:0] npc, imem_addr, imem_rdata;
   logic        imem_req, imem_ready, stall_id;
   logic [1:0]  pcsource;
   logic [31:0] bpc, rpc, jpc;
   logic [31:0] dpc4, inst;
   logic        inst_valid;
   logic [1:0]  fsm_state;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_HOLD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk(clk), .clrn(clrn), .pc(pc), .npc(npc),
      .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(imem_rdata), .imem_ready(imem_ready),
      .stall_id(stall_id), .pcsource(pcsource),
      .bpc(bpc), .rpc(rpc), .jpc(jpc),
      .dpc4(dpc4), .inst(inst), .inst_valid(inst_valid),
      .fsm_state(fsm_state)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // program_counter model: no enable, loads npc every edge
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) pc <= 32'd0;
      else       pc <= npc;
   end

   assign imem_rdata = word(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] e_dpc4,
                             input logic [31:0] e_inst, input logic e_valid);
      check({tag, ".dpc4"}, dpc4, e_dpc4);
      check({tag, ".inst"}, inst, e_inst);
      check({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
   endtask

   initial begin
      clrn = 1'b0; imem_ready = 1'b1; stall_id = 1'b0; pcsource = 2'b00;
      bpc = 32'd0; rpc = 32'd0; jpc = 32'd0;
      @(negedge clk);
      // reset state
      check_ifid("rst", 32'd0, 32'd0, 1'b0);
      check("rst.req", {31'd0, imem_req}, 32'd1);
      check("rst.addr", imem_addr, 32'd0);
      check("rst.state", {30'd0, fsm_state}, {30'd0, S_FETCH});
      clrn = 1'b1;
      #1 check("zw.npc0", npc, 32'd4);
      // zero-wait streaming
      tick();
      check_ifid("zw.e1", 32'd4, word(32'd0), 1'b1);
      check("zw.pc1", pc, 32'd4);
      check("zw.npc1", npc, 32'd8);
      tick();
      check_ifid("zw.e2", 32'd8, word(32'd4), 1'b1);
      // wait states at pc=8
      imem_ready = 1'b0;
      #1 check("ws.npc_a", npc, 32'd8);
      check("ws.req_a", {31'd0, imem_req}, 32'd1);
      tick();
      check("ws.valid_a", {31'd0, inst_valid}, 32'd0);
      check("ws.npc_b", npc, 32'd8);
      tick();
      check("ws.valid_b", {31'd0, inst_valid}, 32'd0);
      check("ws.pc_b", pc, 32'd8);
      imem_ready = 1'b1;
      #1 check("ws.npc_rdy", npc, 32'hC);
      tick();
      check_ifid("ws.load", 32'hC, word(32'd8), 1'b1);
      // jump to 0x20, then branch away with the fetch ready
      pcsource = 2'b11; jpc = 32'h20;
      #1 check("br.jnpc", npc, 32'h20);
      tick();
      check("br.pc", pc, 32'h20);
      pcsource = 2'b01; bpc = 32'h100;
      #1 check("br.npc", npc, 32'h100);
      tick();
      check_ifid("br.bubble", 32'd0, 32'd0, 1'b0);
      check("br.pc2", pc, 32'h100);
      pcsource = 2'b00;
      #1 check("br.npc2", npc, 32'h104);
      tick();
      check_ifid("br.tgt", 32'h104, word(32'h100), 1'b1);
      // jump into a slow fetch at 0x10
      pcsource = 2'b11; jpc = 32'h10;
      tick();
      check("dr.pc0", pc, 32'h10);
      jpc = 32'h200; imem_ready = 1'b0;
      #1 check("dr.npc0", npc, 32'h10);
      tick();
      pcsource = 2'b00;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("dr.state", {30'd0, fsm_state}, {30'd0, S_DRAIN});
         check("dr.pc", pc, 32'h10);
         check("dr.req", {31'd0, imem_req}, 32'd1);
         check("dr.npc", npc, 32'h10);
         check("dr.valid", {31'd0, inst_valid}, 32'd0);
         tick();
      end
      imem_ready = 1'b1;
      #1 check("dr.npc_rdy", npc, 32'h200);
      check("dr.addr_rdy", imem_addr, 32'h10);
      tick();
      check("dr.pc_tgt", pc, 32'h200);
      check("dr.state_f", {30'd0, fsm_state}, {30'd0, S_FETCH});
      check("dr.valid_f", {31'd0, inst_valid}, 32'd0);
      check("dr.npc_f", npc, 32'h204);
      // stall with a ready fetch at 0x40
      pcsource = 2'b11; jpc = 32'h3C;
      tick();
      pcsource = 2'b00;
      tick();
      check_ifid("st.pre", 32'h40, word(32'h3C), 1'b1);
      stall_id = 1'b1;
      #1 check("st.npc0", npc, 32'h40);
      tick();
      for (int i = 0; i < 2; i++) begin
         check("st.state", {30'd0, fsm_state}, {30'd0, S_HOLD});
         check("st.req", {31'd0, imem_req}, 32'd0);
         check("st.npc", npc, 32'h40);
         check_ifid("st.held", 32'h40, word(32'h3C), 1'b1);
         if (i == 0) tick();
      end
      stall_id = 1'b0; imem_ready = 1'b0;
      #1 check("st.npc_rel", npc, 32'h44);
      tick();
      check_ifid("st.rel", 32'h44, word(32'h40), 1'b1);
      check("st.pc", pc, 32'h44);
      // reset while draining a register-jump redirect
      pcsource = 2'b10; rpc = 32'h300;
      tick();
      pcsource = 2'b00;
      check("rd.state", {30'd0, fsm_state}, {30'd0, S_DRAIN});
      #2 clrn = 1'b0;
      #1;
      check("rd.state0", {30'd0, fsm_state}, {30'd0, S_FETCH});
      check("rd.req0", {31'd0, imem_req}, 32'd1);
      check("rd.addr0", imem_addr, 32'd0);
      clrn = 1'b1; imem_ready = 1'b1;
      #1 check("rd.npc", npc, 32'd4);
      tick();
      check_ifid("rd.post", 32'd4, word(32'd0), 1'b1);
      // reset while holding a valid IF/ID entry
      stall_id = 1'b1;
      tick();
      check("rh.state", {30'd0, fsm_state}, {30'd0, S_HOLD});
      #2 clrn = 1'b0;
      #1;
      check_ifid("rh.rst", 32'd0, 32'd0, 1'b0);
      check("rh.state0", {30'd0, fsm_state}, {30'd0, S_FETCH});
      clrn = 1'b1; stall_id = 1'b0;
      tick();
      check_ifid("rh.post", 32'd4, word(32'd0), 1'b1);
      // pc+4 wraps at the top of the address space
      pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
      tick();
      pcsource = 2'b00;
      #1 check("wr.npc", npc, 32'd0);
      tick();
      check_ifid("wr.ifid", 32'd0, word(32'hFFFF_FFFC), 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
